// File: rtl/video_timing_pattern_gen_if.sv
// Pixel-domain bundle between the timing/pattern source and its video consumer.
// The master modport is the generator side; the slave modport is the sink/controller side.
interface video_timing_pattern_gen_if #(
    parameter int DW = 8
);
    logic            I_en;
    logic [2:0]      I_mode;
    logic [3*DW-1:0] I_solid_rgb;
    logic            O_vs;
    logic            O_hs;
    logic            O_de;
    logic [DW-1:0]   O_r;
    logic [DW-1:0]   O_g;
    logic [DW-1:0]   O_b;
    logic [15:0]     O_frame_cnt;
    logic            O_busy;

    modport master (
        input  I_en, I_mode, I_solid_rgb,
        output O_vs, O_hs, O_de, O_r, O_g, O_b, O_frame_cnt, O_busy
    );

    modport slave (
        output I_en, I_mode, I_solid_rgb,
        input  O_vs, O_hs, O_de, O_r, O_g, O_b, O_frame_cnt, O_busy
    );
endinterface

// File: rtl/video_timing_pattern_gen.sv
// Parametrised raster timing generator with five test patterns, frame counter and
// frame-aligned start/stop; every output is registered one cycle after its h/v position.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 160,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 16,
    parameter int H_BP     = 16,
    parameter int V_ACTIVE = 120,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 4,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int DW       = 8
) (
    input  logic                      I_rgb_clk,
    input  logic                      I_rst,
    video_timing_pattern_gen_if.master vid
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int BOX_SZ   = 16;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic          HS_ACT = (HS_POL != 0);
    localparam logic          VS_ACT = (VS_POL != 0);

    // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    generate
        if (H_ACTIVE < 16 || V_ACTIVE < 1 || DW < 1 || DW > 12 ||
            H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
            $error("video_timing_pattern_gen: illegal raster or colour-depth parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [HW-1:0]   box_x_q, box_x_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [2:0]      mode_q, mode_d;
    logic [3*DW-1:0] solid_q, solid_d;
    logic            busy_q, busy_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic            de_q, de_d;
    logic [3*DW-1:0] rgb_q, rgb_d;

    logic            frame_start;
    logic [2:0]      mode_cur;
    logic [3*DW-1:0] solid_cur;
    logic [31:0]     x_ext, y_ext, box_ext;
    logic            box_wrap;
    logic            in_active, in_hs, in_vs;
    logic [2:0]      bar;
    logic [3*DW-1:0] pix_rgb;

    assign x_ext   = 32'(h_q);
    assign y_ext   = 32'(v_q);
    assign box_ext = 32'(box_x_q);

    // The box advances once per frame and restarts at 0 when it would leave the active area.
    assign box_wrap = (box_ext + 32'(BOX_SZ + 1)) > 32'(H_ACTIVE);

    // Mode and colour are sampled at (0,0); that first pixel already uses the new values.
    assign frame_start = (state_q != ST_IDLE) && (h_q == '0) && (v_q == '0);
    assign mode_cur    = frame_start ? vid.I_mode      : mode_q;
    assign solid_cur   = frame_start ? vid.I_solid_rgb : solid_q;
    assign mode_d      = mode_cur;
    assign solid_d     = solid_cur;

    assign in_active = (x_ext < 32'(H_ACTIVE)) && (y_ext < 32'(V_ACTIVE));
    assign in_hs     = (x_ext >= 32'(HS_START)) && (x_ext < 32'(HS_END));
    assign in_vs     = (y_ext >= 32'(VS_START)) && (y_ext < 32'(VS_END));

    always_comb begin : fsm_counters
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        frame_cnt_d = frame_cnt_q;
        box_x_d     = box_x_q;
        case (state_q)
            ST_IDLE: begin
                if (vid.I_en) begin
                    state_d = ST_RUN;
                    box_x_d = '0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                state_d = vid.I_en ? ST_RUN : ST_DRAIN;
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == V_LAST) begin
                        v_d         = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        box_x_d     = box_wrap ? '0 : box_x_q + HW'(1);
                        if (!vid.I_en) state_d = ST_IDLE;
                    end else begin
                        v_d = v_q + VW'(1);
                    end
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : pattern
        bar     = 3'd0;
        pix_rgb = '0;
        for (int k = 1; k < 8; k++) begin
            if (x_ext >= 32'(k * BAR_W)) bar = 3'(k);
        end
        case (mode_cur)
            3'd0: pix_rgb = solid_cur;
            3'd1: pix_rgb = {{DW{BAR_RGB[bar][2]}}, {DW{BAR_RGB[bar][1]}}, {DW{BAR_RGB[bar][0]}}};
            3'd2: pix_rgb = {3{x_ext[DW-1:0]}};
            3'd3: begin
                if ((x_ext[3:0] == 4'd0) || (y_ext[3:0] == 4'd0) ||
                    (x_ext == 32'(H_ACTIVE - 1)) || (y_ext == 32'(V_ACTIVE - 1)))
                    pix_rgb = '1;
            end
            3'd4: begin
                if ((x_ext >= box_ext) && (x_ext < box_ext + 32'(BOX_SZ)) &&
                    (y_ext < 32'(BOX_SZ)))
                    pix_rgb = '1;
            end
            default: pix_rgb = '0;
        endcase
    end

    always_comb begin : video_out
        busy_d = (state_q != ST_IDLE);
        de_d   = 1'b0;
        hs_d   = ~HS_ACT;
        vs_d   = ~VS_ACT;
        rgb_d  = '0;
        if (state_q != ST_IDLE) begin
            de_d = in_active;
            hs_d = in_hs ? HS_ACT : ~HS_ACT;
            vs_d = in_vs ? VS_ACT : ~VS_ACT;
            if (in_active) rgb_d = pix_rgb;
        end
    end

    always_ff @(posedge I_rgb_clk or posedge I_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (I_rst) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            box_x_q     <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            busy_q      <= 1'b0;
            hs_q        <= ~HS_ACT;
            vs_q        <= ~VS_ACT;
            de_q        <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            box_x_q     <= box_x_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            busy_q      <= busy_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            rgb_q       <= rgb_d;
        end
    end

    assign vid.O_vs        = vs_q;
    assign vid.O_hs        = hs_q;
    assign vid.O_de        = de_q;
    assign vid.O_r         = rgb_q[3*DW-1:2*DW];
    assign vid.O_g         = rgb_q[2*DW-1:DW];
    assign vid.O_b         = rgb_q[DW-1:0];
    assign vid.O_frame_cnt = frame_cnt_q;
    assign vid.O_busy      = busy_q;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Scoreboard bench: a frame-position reference model queues the expected outputs of every
// clock edge and a negedge monitor compares them against the generator on a small raster.
module tb_video_timing_pattern_gen;

    localparam int HA = 40, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 18, VFP = 1, VSY = 2, VBP = 2;
    localparam int HSP = 1, VSP = 0, DW = 5;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int OW = 3 + 3*DW + 16 + 1;

    typedef struct {
        logic            vs, hs, de;
        logic [3*DW-1:0] rgb;
        logic [15:0]     fc;
        logic            busy;
        int              x, y;
    } exp_t;

    bit   clk;
    logic rst;
    bit   done;
    int   n_checks, n_pass;
    exp_t exp_q[$];

    // model state
    bit              m_active;
    int              m_p, m_box;
    logic [15:0]     m_fc;
    logic [2:0]      m_mode;
    logic [3*DW-1:0] m_solid;

    video_timing_pattern_gen_if #(.DW(DW)) vif ();

    video_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .DW(DW)
    ) dut (
        .I_rgb_clk(clk),
        .I_rst(rst),
        .vid(vif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [3*DW-1:0] pixel(input int x, input int y, input logic [2:0] mode,
                                              input logic [3*DW-1:0] solid, input int box);
        logic [2:0] bars [8];
        logic [2:0] c;
        int bar;
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        case (mode)
            3'd0: return solid;
            3'd1: begin
                bar = x / (HA / 8);
                if (bar > 7) bar = 7;
                c = bars[bar];
                return {{DW{c[2]}}, {DW{c[1]}}, {DW{c[0]}}};
            end
            3'd2: return {3{DW'(x % (1 << DW))}};
            3'd3: return (x % 16 == 0 || y % 16 == 0 || x == HA - 1 || y == VA - 1) ? '1 : '0;
            3'd4: return (x >= box && x < box + 16 && y < 16) ? '1 : '0;
            default: return '0;
        endcase
    endfunction

    function automatic exp_t idle_exp(input logic [15:0] fc);
        exp_t e;
        e.vs = (VSP == 0); e.hs = (HSP == 0); e.de = 1'b0; e.rgb = '0;
        e.fc = fc; e.busy = 1'b0; e.x = -1; e.y = -1;
        return e;
    endfunction

    // Reference model: a running frame is a linear pixel index 0..FRAME-1.
    always @(posedge clk) begin
        exp_t e;
        int x, y;
        if (rst) begin
            m_active = 0; m_p = 0; m_fc = '0; m_box = 0;
            m_mode = '0; m_solid = '0;
            e = idle_exp(16'd0);
        end else if (!m_active) begin
            e = idle_exp(m_fc);
            if (vif.I_en) begin
                m_active = 1; m_p = 0; m_box = 0;
            end
        end else begin
            x = m_p % HT;
            y = m_p / HT;
            if (m_p == 0) begin
                m_mode  = vif.I_mode;
                m_solid = vif.I_solid_rgb;
            end
            e.x = x; e.y = y;
            e.de   = (x < HA) && (y < VA);
            e.hs   = (x >= HA + HFP && x < HA + HFP + HSY) ? (HSP != 0) : (HSP == 0);
            e.vs   = (y >= VA + VFP && y < VA + VFP + VSY) ? (VSP != 0) : (VSP == 0);
            e.rgb  = e.de ? pixel(x, y, m_mode, m_solid, m_box) : '0;
            e.busy = 1'b1;
            if (m_p == FRAME - 1) begin
                m_fc++;
                m_box = (m_box + 1 + 16 > HA) ? 0 : m_box + 1;
                m_active = vif.I_en;
                m_p = 0;
            end else begin
                m_p++;
            end
            e.fc = m_fc;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        logic [OW-1:0] act;
        if (!done) begin
            act = {vif.O_vs, vif.O_hs, vif.O_de, vif.O_r, vif.O_g, vif.O_b,
                   vif.O_frame_cnt, vif.O_busy};
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty got=%h expected=queued entry (t=%0t)", act, $time);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("pix(x=%0d,y=%0d)", e.x, e.y), act,
                      {e.vs, e.hs, e.de, e.rgb, e.fc, e.busy});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog got=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        vif.I_en = 1'b0;
        vif.I_mode = 3'd1;
        vif.I_solid_rgb = '0;
        step(3);
        rst = 1'b0;
        step(6);

        // colour bars, continuous frames
        vif.I_en = 1'b1;
        step(2 * FRAME + 7);

        // drain with re-assert mid-frame: no gap
        vif.I_en = 1'b0;
        step(4 * HT);
        vif.I_en = 1'b1;
        step(FRAME);

        // drain to completion then idle gap
        vif.I_en = 1'b0;
        step(FRAME + 30);

        // mode latch: solid then grid mid-frame
        vif.I_mode = 3'd0;
        vif.I_solid_rgb = (3*DW)'($urandom);
        vif.I_en = 1'b1;
        step(10 * HT + 3);
        vif.I_mode = 3'd3;
        vif.I_solid_rgb = (3*DW)'($urandom);
        step(2 * FRAME);

        // ramp one frame
        vif.I_mode = 3'd2;
        step(FRAME);

        // reset mid-frame with moving box queued for the restart
        step(5 * HT + 11);
        rst = 1'b1;
        vif.I_mode = 3'd4;
        step(5);
        rst = 1'b0;
        step(27 * FRAME);

        // randomized run/stop, mode and colour changes, occasional reset
        repeat (40) begin
            vif.I_en = ($urandom_range(0, 3) != 0);
            vif.I_mode = 3'($urandom_range(0, 7));
            vif.I_solid_rgb = (3*DW)'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                step(2);
                rst = 1'b0;
            end
            step($urandom_range(50, 400));
        end

        vif.I_en = 1'b0;
        step(FRAME + 5);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
